// File: rtl/bp.sv
// bp: direct-mapped BTB with 2-bit saturating counters, registered 1-cycle lookup
module bp #(
  parameter int XLEN = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            predict_valid,
  input  logic [XLEN-1:0] predict_src,
  output logic            predict_ack,
  output logic            predict_hit,
  output logic            predict_taken,
  output logic [XLEN-1:0] predict_dst,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;
  logic [ENTRIES-1:0] v;
  logic [TW-1:0]   tag_q [ENTRIES];
  logic [XLEN-1:0] tgt_q [ENTRIES];
  logic [1:0]      ctr_q [ENTRIES];
  logic [IW-1:0] rd_idx, wr_idx;
  logic [TW-1:0] rd_tag, wr_tag;
  logic rd_hit, wr_hit;
  logic [1:0] ctr_nxt;
  logic unused_bits;
  assign unused_bits = ^{predict_src[1:0], upd_pc[1:0]};
  always_comb begin
    rd_idx = predict_src[IW+1:2];
    rd_tag = predict_src[XLEN-1:IW+2];
    wr_idx = upd_pc[IW+1:2];
    wr_tag = upd_pc[XLEN-1:IW+2];
    rd_hit = v[rd_idx] && tag_q[rd_idx] == rd_tag;
    wr_hit = v[wr_idx] && tag_q[wr_idx] == wr_tag;
    ctr_nxt = upd_taken ? (ctr_q[wr_idx] == 2'b11 ? 2'b11 : ctr_q[wr_idx] + 2'd1)
                        : (ctr_q[wr_idx] == 2'b00 ? 2'b00 : ctr_q[wr_idx] - 2'd1);
  end
  // Response reads pre-update state: table writes land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      predict_ack <= 1'b0;
      predict_hit <= 1'b0;
      predict_taken <= 1'b0;
      predict_dst <= '0;
      v <= '0;
    end else begin
      predict_ack <= predict_valid;
      predict_hit <= predict_valid && rd_hit;
      predict_taken <= predict_valid && rd_hit && ctr_q[rd_idx][1];
      predict_dst <= (predict_valid && rd_hit) ? tgt_q[rd_idx] : '0;
      if (upd_valid && !wr_hit && upd_taken) v[wr_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && upd_valid) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_nxt;
        if (upd_taken) tgt_q[wr_idx] <= upd_target;
      end else if (upd_taken) begin
        tag_q[wr_idx] <= wr_tag;
        tgt_q[wr_idx] <= upd_target;
        ctr_q[wr_idx] <= 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_bp.sv
// tb_bp: directed checks of bp lookup, training, saturation, aliasing and reset
module tb_bp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic predict_valid = 1'b0;
  logic [31:0] predict_src = '0;
  logic predict_ack, predict_hit, predict_taken;
  logic [31:0] predict_dst;
  logic upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  int n_cmp = 0;
  int n_err = 0;

  bp #(.XLEN(32), .ENTRIES(64)) dut (
    .clk(clk), .rst(rst),
    .predict_valid(predict_valid), .predict_src(predict_src),
    .predict_ack(predict_ack), .predict_hit(predict_hit),
    .predict_taken(predict_taken), .predict_dst(predict_dst),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic eh,
                        input logic et, input logic [31:0] ed);
    predict_valid = 1'b1;
    predict_src = pc;
    tick();
    predict_valid = 1'b0;
    chk({tag, ".ack"}, predict_ack, 1);
    chk({tag, ".hit"}, predict_hit, eh);
    chk({tag, ".taken"}, predict_taken, et);
    chk({tag, ".dst"}, predict_dst, ed);
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    upd_valid = 1'b1;
    upd_pc = pc;
    upd_taken = t;
    upd_target = tgt;
    tick();
    upd_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst.ack", predict_ack, 0);
    chk("rst.hit", predict_hit, 0);
    chk("rst.dst", predict_dst, 0);
    rst = 1'b0;
    lookup("empty", 32'h1000, 0, 0, 32'h0);
    tick();
    chk("idle.ack", predict_ack, 0);
    chk("idle.dst", predict_dst, 0);

    update(32'h1000, 1, 32'h2000);
    lookup("alloc", 32'h1000, 1, 1, 32'h2000);
    update(32'h1000, 0, 32'h9999);
    update(32'h1000, 0, 32'h9999);
    lookup("nt2", 32'h1000, 1, 0, 32'h2000);

    for (int i = 0; i < 5; i++) update(32'h1000, 1, 32'h2000);
    update(32'h1000, 0, 32'h0);
    lookup("sat_hi", 32'h1000, 1, 1, 32'h2000);
    for (int i = 0; i < 5; i++) update(32'h1000, 0, 32'h0);
    update(32'h1000, 1, 32'h2000);
    lookup("sat_lo", 32'h1000, 1, 0, 32'h2000);

    lookup("alias_miss", 32'h1100, 0, 0, 32'h0);
    update(32'h1100, 0, 32'h3000);
    lookup("alias_nt", 32'h1000, 1, 0, 32'h2000);
    update(32'h1100, 1, 32'h3000);
    lookup("alias_old", 32'h1000, 0, 0, 32'h0);
    lookup("alias_new", 32'h1100, 1, 1, 32'h3000);

    predict_valid = 1'b1;
    predict_src = 32'h1040;
    upd_valid = 1'b1;
    upd_pc = 32'h1040;
    upd_taken = 1'b1;
    upd_target = 32'h4000;
    tick();
    predict_valid = 1'b0;
    upd_valid = 1'b0;
    chk("rbw.ack", predict_ack, 1);
    chk("rbw.hit", predict_hit, 0);
    chk("rbw.dst", predict_dst, 0);
    lookup("rbw_next", 32'h1040, 1, 1, 32'h4000);

    lookup("b2b0", 32'h1100, 1, 1, 32'h3000);
    lookup("b2b1", 32'h1040, 1, 1, 32'h4000);
    lookup("b2b2", 32'h2000, 0, 0, 32'h0);
    lookup("b2b3", 32'h1044, 0, 0, 32'h0);

    predict_valid = 1'b1;
    predict_src = 32'h1100;
    upd_valid = 1'b1;
    upd_pc = 32'h1000;
    upd_taken = 1'b1;
    upd_target = 32'h5000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    predict_valid = 1'b0;
    upd_valid = 1'b0;
    chk("rstmid.ack", predict_ack, 0);
    chk("rstmid.hit", predict_hit, 0);
    tick();
    chk("rstmid.ack2", predict_ack, 0);
    lookup("post_rst", 32'h1000, 0, 0, 32'h0);
    lookup("post_rst2", 32'h1100, 0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
